// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: configurable UART transmitter.
// Baud tick divider, TX FIFO and frame FSM in one block. Frame format is
// start, DATA_BITS payload (LSB first), optional parity, STOP_BITS stop bits.
// Frames queued in the FIFO go out back-to-back with no idle gap.
module uart_tx_fifo_cfg #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // Baud divider
    logic [DIV_W-1:0] div_cnt;
    logic             b_tick;

    // FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_next;
    logic                 fifo_empty;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    // Frame FSM
    state_t               state, state_next;
    logic [OS_W-1:0]      tick_cnt, tick_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shreg, sh_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 done;
    logic                 bit_end;

    assign b_tick = (div_cnt == DIV_W'(DIV - 1));

    // Free-running divider, wraps at DIV-1 and emits one b_tick per wrap.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (b_tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign push       = tx_start & ~tx_full;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign head       = mem[rd_ptr];

    // FIFO storage write port.
    // NOTE: the storage array is not reset; pointers and count define validity, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_full    <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            tx_full    <= (count_next == CNT_W'(FIFO_DEPTH));
            fifo_empty <= (count_next == '0);
        end
    end

    assign bit_end = b_tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));

    // Next-state, datapath updates and line level for the frame FSM.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        sh_next    = shreg;
        par_next   = par_bit;
        pop        = 1'b0;
        done       = 1'b0;

        if (b_tick && state != IDLE)
            tick_next = bit_end ? '0 : tick_cnt + OS_W'(1);

        unique case (state)
            IDLE: begin
                if (b_tick && !fifo_empty) begin
                    pop        = 1'b1;
                    sh_next    = head;
                    par_next   = (PARITY == 2) ? ^head : ~^head;
                    tick_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_next = shreg >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        done     = 1'b1;
                        bit_next = '0;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            sh_next    = head;
                            par_next   = (PARITY == 2) ? ^head : ~^head;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level follows the state being entered, so tx is a clean register output.
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[0];
            PAR:     tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shreg    <= sh_next;
            par_bit  <= par_next;
            tx       <= tx_next;
        end
    end

    assign tx_done = done;
    assign tx_busy = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: self-checking bench for uart_tx_fifo_cfg.
// Four instances (8N1, 8E1, 8O1, 7N2) share clk/rst; a line decoder samples the
// selected instance mid-bit and compares frames against a scoreboard queue.
module tb_uart_tx_fifo_cfg;

    localparam int CLK_T    = 307_200;
    localparam int BAUD_T   = 9600;
    localparam int OS_T     = 4;
    localparam int DIV_T    = 8;            // 307200 / (9600 * 4)
    localparam int BIT      = OS_T * DIV_T; // clocks per bit
    localparam int WAIT_MAX = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [7:0] data_bus = '0;
    logic [3:0] full_v, busy_v, done_v, tx_v;
    logic [1:0] sel = '0;
    logic       tx_m, done_m, busy_m, full_m;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         push_cyc = 0;
    int         done_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (done_v[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
    end

    assign tx_m   = tx_v[sel];
    assign done_m = done_v[sel];
    assign busy_m = busy_v[sel];
    assign full_m = full_v[sel];

    uart_tx_fifo_cfg #(.CLK_FREQ(CLK_T), .BAUD(BAUD_T), .OVERSAMPLE(OS_T), .DATA_BITS(8),
                       .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .tx_start(start_v[0]), .tx_data(data_bus[7:0]),
        .tx_full(full_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

    uart_tx_fifo_cfg #(.CLK_FREQ(CLK_T), .BAUD(BAUD_T), .OVERSAMPLE(OS_T), .DATA_BITS(8),
                       .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
        .clk(clk), .rst(rst), .tx_start(start_v[1]), .tx_data(data_bus[7:0]),
        .tx_full(full_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

    uart_tx_fifo_cfg #(.CLK_FREQ(CLK_T), .BAUD(BAUD_T), .OVERSAMPLE(OS_T), .DATA_BITS(8),
                       .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .rst(rst), .tx_start(start_v[2]), .tx_data(data_bus[7:0]),
        .tx_full(full_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

    uart_tx_fifo_cfg #(.CLK_FREQ(CLK_T), .BAUD(BAUD_T), .OVERSAMPLE(OS_T), .DATA_BITS(7),
                       .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .rst(rst), .tx_start(start_v[3]), .tx_data(data_bus[6:0]),
        .tx_full(full_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

    typedef struct {
        logic [1:0] inst;
        logic [7:0] data;
        logic       exp_par;
        int         exp_bits;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // One-cycle push strobe to instance s; scoreboard entry recorded when acceptance is expected.
    task automatic push_word(input logic [1:0] s, input logic [7:0] d, input bit accept);
        @(negedge clk);
        data_bus   = d;
        start_v[s] = 1'b1;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        start_v  = '0;
        push_cyc = cyc;
    endtask

    // Decode one frame from the selected line, sampling each bit at its midpoint.
    task automatic rx_frame(input int nd, input bit hp, input int ns,
                            output logic [7:0] d, output logic p, output bit framing_ok,
                            output int t0, output int t1, output bit to);
        int n;
        d = '0; p = 1'b0; framing_ok = 1'b1; to = 1'b0; t0 = 0; t1 = 0;
        n = 0;
        @(negedge clk);
        while (tx_m !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (tx_m !== 1'b0) begin
            to = 1'b1;
            return;
        end
        t0 = cyc;
        repeat (BIT / 2) @(negedge clk);
        if (tx_m !== 1'b0) framing_ok = 1'b0;
        for (int i = 0; i < nd; i++) begin
            repeat (BIT) @(negedge clk);
            d[i] = tx_m;
        end
        if (hp) begin
            repeat (BIT) @(negedge clk);
            p = tx_m;
        end
        for (int i = 0; i < ns; i++) begin
            repeat (BIT) @(negedge clk);
            if (tx_m !== 1'b1) framing_ok = 1'b0;
        end
        n = 0;
        while (done_m !== 1'b1 && n < BIT) begin
            @(negedge clk);
            n++;
        end
        if (done_m !== 1'b1) begin
            to = 1'b1;
            return;
        end
        t1 = cyc;
    endtask

    // Receive a frame from the selected instance and score it against the queue head.
    task automatic recv(input string tag, input logic exp_par, input int exp_bits,
                        output int t0, output int t1);
        int         nd, ns;
        bit         hp, ok, to;
        logic [7:0] d, e, mask;
        logic       p;
        nd = (sel == 2'd3) ? 7 : 8;
        ns = (sel == 2'd3) ? 2 : 1;
        hp = (sel == 2'd1) || (sel == 2'd2);
        rx_frame(nd, hp, ns, d, p, ok, t0, t1, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_frame"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        if (to) return;
        mask = (nd == 7) ? 8'h7F : 8'hFF;
        check({tag, "_data"}, 32'(d), 32'(e & mask));
        if (hp) check({tag, "_parity"}, 32'(p), 32'(exp_par));
        check({tag, "_framing"}, 32'(ok), 32'd1);
        check({tag, "_length"}, 32'(t1 - t0), 32'(exp_bits * BIT - 1));
    endtask

    // Line must stay idle high for the whole window.
    task automatic quiet(input string tag, input int cycles);
        bit saw_low;
        saw_low = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_m !== 1'b1) saw_low = 1'b1;
        end
        check(tag, 32'(saw_low), 32'd0);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not complete within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0 [5];
        int t1 [5];
        int d0, lat, tr0, tr1;

        vecs[0] = '{2'd0, 8'h55, 1'b0, 10};
        vecs[1] = '{2'd0, 8'h00, 1'b0, 10};
        vecs[2] = '{2'd0, 8'hFF, 1'b0, 10};
        vecs[3] = '{2'd1, 8'h07, 1'b1, 11};
        vecs[4] = '{2'd2, 8'h07, 1'b0, 11};
        vecs[5] = '{2'd1, 8'h00, 1'b0, 11};
        vecs[6] = '{2'd2, 8'h80, 1'b0, 11};
        vecs[7] = '{2'd3, 8'h3C, 1'b0, 10};
        vecs[8] = '{2'd3, 8'h7F, 1'b0, 10};

        // Reset values on every instance.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_tx_%0d", i),   32'(tx_v[i]),   32'd1);
            check($sformatf("reset_busy_%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset_full_%0d", i), 32'(full_v[i]), 32'd0);
            check($sformatf("reset_done_%0d", i), 32'(done_v[i]), 32'd0);
        end

        // Five pushes on consecutive cycles right after reset: the fifth is dropped.
        rst = 1'b0;
        sel = 2'd0;
        for (int k = 0; k < 5; k++) begin
            data_bus   = 8'h11 + 8'(k);
            start_v[0] = 1'b1;
            if (k < 4) exp_q.push_back(8'h11 + 8'(k));
            @(negedge clk);
            if (k == 3) check("burst_full_after_4th", 32'(full_m), 32'd1);
            if (k == 4) check("burst_full_after_5th", 32'(full_m), 32'd1);
        end
        start_v = '0;
        check("burst_busy", 32'(busy_m), 32'd1);
        for (int k = 0; k < 4; k++) begin
            recv($sformatf("burst_f%0d", k), 1'b0, 10, t0[k], t1[k]);
            if (k > 0) check($sformatf("burst_gap_%0d", k), 32'(t0[k]), 32'(t1[k-1] + 1));
        end
        repeat (2) @(negedge clk);
        check("burst_busy_end", 32'(busy_m), 32'd0);
        check("burst_done_pulses", 32'(done_cnt[0]), 32'd4);
        quiet("burst_no_fifth_frame", 12 * BIT);
        check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Single frames from the vector table.
        foreach (vecs[v]) begin
            sel = vecs[v].inst;
            d0  = done_cnt[vecs[v].inst];
            push_word(vecs[v].inst, vecs[v].data, 1'b1);
            recv($sformatf("vec%0d", v), vecs[v].exp_par, vecs[v].exp_bits, tr0, tr1);
            lat = tr0 - push_cyc;
            check($sformatf("vec%0d_latency", v), 32'(lat >= 1 && lat <= DIV_T + 1), 32'd1);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_busy_end", v), 32'(busy_m), 32'd0);
            check($sformatf("vec%0d_done_once", v), 32'(done_cnt[vecs[v].inst] - d0), 32'd1);
        end

        // Reset during DATA bit 3 of 0xA5 with a second word still queued.
        do_reset();
        sel = 2'd0;
        push_word(2'd0, 8'hA5, 1'b0);
        push_word(2'd0, 8'h3C, 1'b0);
        lat = 0;
        while (tx_m !== 1'b0 && lat < WAIT_MAX) begin
            @(negedge clk);
            lat++;
        end
        check("abort_frame_started", 32'(tx_m), 32'd0);
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        check("abort_in_data_bit3", 32'(tx_m), 32'd0);
        d0  = done_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_high", 32'(tx_m), 32'd1);
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_full", 32'(full_m), 32'd0);
        rst = 1'b0;
        quiet("abort_fifo_flushed", 12 * BIT);
        check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("abort_busy_later", 32'(busy_m), 32'd0);

        // Full FIFO, push 0xFF in the very cycle of a pop: it must never be sent.
        do_reset();
        sel = 2'd0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    recv($sformatf("popdrop_f%0d", k), 1'b0, 10, t0[k], t1[k]);
            end
            begin
                push_word(2'd0, 8'h21, 1'b1);
                lat = 0;
                while (busy_m === 1'b1 && tx_m !== 1'b0 && lat < WAIT_MAX) begin
                    @(negedge clk);
                    lat++;
                end
                for (int k = 0; k < 4; k++) push_word(2'd0, 8'h22 + 8'(k), 1'b1);
                check("popdrop_full", 32'(full_m), 32'd1);
                lat = 0;
                while (done_m !== 1'b1 && lat < WAIT_MAX) begin
                    @(negedge clk);
                    lat++;
                end
                check("popdrop_done_seen", 32'(done_m), 32'd1);
                data_bus   = 8'hFF;
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v = '0;
                check("popdrop_full_after_pop", 32'(full_m), 32'd0);
            end
        join
        repeat (2) @(negedge clk);
        check("popdrop_busy_end", 32'(busy_m), 32'd0);
        quiet("popdrop_no_ff_frame", 12 * BIT);
        check("popdrop_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
